// File: rtl/alu_uart_intf_if.sv
// alu_uart_intf_if: byte/ALU/transmitter signal bundle for the UART-ALU sequencing stage
interface alu_uart_intf_if #(
  parameter int DATA_WIDTH = 8,
  parameter int OP_WIDTH   = 6
);
  logic                  i_rx_done;
  logic [DATA_WIDTH-1:0] i_rx_data;
  logic [DATA_WIDTH-1:0] i_alu_result;
  logic                  i_tx_done;
  logic [DATA_WIDTH-1:0] o_alu_a;
  logic [DATA_WIDTH-1:0] o_alu_b;
  logic [OP_WIDTH-1:0]   o_alu_op;
  logic                  o_tx_start;
  logic [DATA_WIDTH-1:0] o_tx_data;
  logic                  o_busy;
  logic                  o_err;
  logic                  o_drop;
  modport slave (
    input  i_rx_done, i_rx_data, i_alu_result, i_tx_done,
    output o_alu_a, o_alu_b, o_alu_op, o_tx_start, o_tx_data, o_busy, o_err, o_drop
  );
  modport master (
    output i_rx_done, i_rx_data, i_alu_result, i_tx_done,
    input  o_alu_a, o_alu_b, o_alu_op, o_tx_start, o_tx_data, o_busy, o_err, o_drop
  );
endinterface

// File: rtl/alu_uart_intf.sv
// alu_uart_intf: collects opcode/A/B bytes, runs the external ALU, hands the result to the UART transmitter; ALU_UART_INTF_TIMEOUT_EN adds an inter-byte timeout
module alu_uart_intf #(
  parameter int DATA_WIDTH   = 8,
  parameter int OP_WIDTH     = 6,
  parameter int TIMEOUT_CLKS = 52080
) (
  input  logic            i_clk,
  input  logic            i_reset,
  alu_uart_intf_if.slave  bus
);
  typedef enum logic [2:0] {WAIT_OP, WAIT_A, WAIT_B, EXEC, SEND, WAIT_TX} state_t;
  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, tx_q, tx_d;
  logic [OP_WIDTH-1:0]   op_q, op_d;
  logic                  err_q, err_d, drop_q, drop_d;
  logic [OP_WIDTH-1:0]   rx_op;
  logic                  op_ok, busy;
  assign rx_op = bus.i_rx_data[OP_WIDTH-1:0];
  assign op_ok = ((bus.i_rx_data >> OP_WIDTH) == '0) &&
                 (rx_op inside {OP_WIDTH'(6'h20), OP_WIDTH'(6'h22), OP_WIDTH'(6'h24), OP_WIDTH'(6'h25),
                                OP_WIDTH'(6'h26), OP_WIDTH'(6'h03), OP_WIDTH'(6'h02), OP_WIDTH'(6'h27)});
  assign busy  = state_q inside {EXEC, SEND, WAIT_TX};
`ifdef ALU_UART_INTF_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CLKS);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          waiting;
  assign waiting = state_q inside {WAIT_A, WAIT_B};
`endif
  // Sequence byte collection, execution and transmit handshake
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    tx_d    = tx_q;
    err_d   = 1'b0;
    drop_d  = bus.i_rx_done && busy;
    case (state_q)
      WAIT_OP: if (bus.i_rx_done) begin
        if (op_ok) begin
          op_d    = rx_op;
          state_d = WAIT_A;
        end else err_d = 1'b1;
      end
      WAIT_A: if (bus.i_rx_done) begin
        a_d     = bus.i_rx_data;
        state_d = WAIT_B;
      end
      WAIT_B: if (bus.i_rx_done) begin
        b_d     = bus.i_rx_data;
        state_d = EXEC;
      end
      EXEC: begin
        tx_d    = bus.i_alu_result;
        state_d = SEND;
      end
      SEND:    state_d = WAIT_TX;
      WAIT_TX: state_d = bus.i_tx_done ? WAIT_OP : WAIT_TX;
      default: state_d = WAIT_OP;
    endcase
`ifdef ALU_UART_INTF_TIMEOUT_EN
    cnt_d = (waiting && !bus.i_rx_done) ? cnt_q + 1'b1 : '0;
    if (waiting && !bus.i_rx_done && cnt_q == CW'(TIMEOUT_CLKS - 1)) begin
      err_d   = 1'b1;
      state_d = WAIT_OP;
      cnt_d   = '0;
    end
`endif
  end
  // State and datapath registers, cleared asynchronously
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= WAIT_OP;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      tx_q    <= '0;
      err_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tx_q    <= tx_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
    end
  end
`ifdef ALU_UART_INTF_TIMEOUT_EN
  // Inter-byte idle counter
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`endif
  assign bus.o_alu_a    = a_q;
  assign bus.o_alu_b    = b_q;
  assign bus.o_alu_op   = op_q;
  assign bus.o_tx_start = state_q == SEND;
  assign bus.o_tx_data  = tx_q;
  assign bus.o_busy     = busy;
  assign bus.o_err      = err_q;
  assign bus.o_drop     = drop_q;
endmodule

// File: tb/tb_alu_uart_intf.sv
// tb_alu_uart_intf: transaction-level model plus directed vectors for alu_uart_intf
module tb_alu_uart_intf;
  localparam int TO = 52080;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  alu_uart_intf_if #(.DATA_WIDTH(8), .OP_WIDTH(6)) bif ();
  alu_uart_intf #(.DATA_WIDTH(8), .OP_WIDTH(6), .TIMEOUT_CLKS(TO)) dut (
    .i_clk(clk), .i_reset(rst_n), .bus(bif)
  );
  always #5 clk = ~clk;

  function automatic logic [7:0] alu(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h03:   return 8'($signed(a) >>> b);
      6'h02:   return a >> b;
      6'h27:   return ~(a | b);
      default: return 8'h00;
    endcase
  endfunction
  assign bif.i_alu_result = alu(bif.o_alu_op, bif.o_alu_a, bif.o_alu_b);

  // Model: which byte is expected next, and how far a computed result has progressed
  int         m_phase = 0;
  int         m_age = 0;
  int         m_idle = 0;
  logic [7:0] m_op = 0, m_a = 0, m_b = 0, m_tx = 0;
  logic       m_err = 0, m_drop = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_age = 0; m_idle = 0;
      m_op = 0; m_a = 0; m_b = 0; m_tx = 0; m_err = 0; m_drop = 0;
    end else begin
      m_err = 0;
      m_drop = 0;
      if (m_age > 0) begin
        m_drop = bif.i_rx_done;
        if (m_age == 1) m_tx = alu(m_op[5:0], m_a, m_b);
        if (m_age >= 3 && bif.i_tx_done) m_age = 0;
        else if (m_age < 3) m_age++;
      end else if (bif.i_rx_done) begin
        m_idle = 0;
        if (m_phase == 0) begin
          if (bif.i_rx_data inside {8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h03, 8'h02, 8'h27}) begin
            m_op = bif.i_rx_data;
            m_phase = 1;
          end else m_err = 1;
        end else if (m_phase == 1) begin
          m_a = bif.i_rx_data;
          m_phase = 2;
        end else begin
          m_b = bif.i_rx_data;
          m_phase = 0;
          m_age = 1;
        end
      end
`ifdef ALU_UART_INTF_TIMEOUT_EN
      else if (m_phase != 0) begin
        m_idle++;
        if (m_idle == TO) begin
          m_err = 1;
          m_phase = 0;
          m_idle = 0;
        end
      end
`endif
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every output against the model on each falling edge
  always @(negedge clk) begin
    chk("op", 32'(bif.o_alu_op), 32'(m_op[5:0]));
    chk("a", 32'(bif.o_alu_a), 32'(m_a));
    chk("b", 32'(bif.o_alu_b), 32'(m_b));
    chk("tx_data", 32'(bif.o_tx_data), 32'(m_tx));
    chk("tx_start", 32'(bif.o_tx_start), 32'(m_age == 2));
    chk("busy", 32'(bif.o_busy), 32'(m_age > 0));
    chk("err", 32'(bif.o_err), 32'(m_err));
    chk("drop", 32'(bif.o_drop), 32'(m_drop));
  end

  task automatic send_byte(input logic [7:0] d);
    @(posedge clk); #1;
    bif.i_rx_done = 1'b1;
    bif.i_rx_data = d;
    @(posedge clk); #1;
    bif.i_rx_done = 1'b0;
  endtask

  task automatic pulse_tx_done();
    @(posedge clk); #1;
    bif.i_tx_done = 1'b1;
    @(posedge clk); #1;
    bif.i_tx_done = 1'b0;
  endtask

  task automatic txn(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp);
    send_byte(op);
    send_byte(a);
    send_byte(b);
    chk("lat_exec_nostart", 32'(bif.o_tx_start), 32'd0);
    @(posedge clk); #1;
    chk("lat_start", 32'(bif.o_tx_start), 32'd1);
    chk("lit_tx_data", 32'(bif.o_tx_data), 32'(exp));
    chk("lit_op", 32'(bif.o_alu_op), 32'(op[5:0]));
    repeat (3) @(posedge clk);
    pulse_tx_done();
    chk("lit_idle", 32'(bif.o_busy), 32'd0);
  endtask

  initial begin
    bif.i_rx_done = 1'b0;
    bif.i_rx_data = 8'h00;
    bif.i_tx_done = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("rst_busy", 32'(bif.o_busy), 32'd0);
    chk("rst_tx", 32'(bif.o_tx_data), 32'd0);
    rst_n = 1'b1;
    pulse_tx_done();
    txn(8'h20, 8'h05, 8'h03, 8'h08);
    chk("lit_a", 32'(bif.o_alu_a), 32'h05);
    chk("lit_b", 32'(bif.o_alu_b), 32'h03);
    txn(8'h03, 8'h80, 8'h01, 8'hC0);
    txn(8'h22, 8'h02, 8'h02, 8'h00);
    send_byte(8'h3F);
    chk("lit_err1", 32'(bif.o_err), 32'd1);
    send_byte(8'hE0);
    chk("lit_err2", 32'(bif.o_err), 32'd1);
    @(posedge clk); #1;
    chk("lit_err_clear", 32'(bif.o_err), 32'd0);
    txn(8'h24, 8'hF0, 8'h3C, 8'h30);
    send_byte(8'h25);
    send_byte(8'h09);
    send_byte(8'h10);
    repeat (3) @(posedge clk);
    send_byte(8'h55);
    chk("lit_drop", 32'(bif.o_drop), 32'd1);
    chk("lit_drop_tx", 32'(bif.o_tx_data), 32'h19);
    @(posedge clk); #1;
    bif.i_rx_done = 1'b1;
    bif.i_rx_data = 8'hAA;
    bif.i_tx_done = 1'b1;
    @(posedge clk); #1;
    bif.i_rx_done = 1'b0;
    bif.i_tx_done = 1'b0;
    chk("lit_both_drop", 32'(bif.o_drop), 32'd1);
    chk("lit_both_idle", 32'(bif.o_busy), 32'd0);
    txn(8'h25, 8'h01, 8'h02, 8'h03);
    send_byte(8'h20);
    send_byte(8'h07);
    rst_n = 1'b0;
    #1;
    chk("lit_rst_op", 32'(bif.o_alu_op), 32'd0);
    chk("lit_rst_a", 32'(bif.o_alu_a), 32'd0);
    chk("lit_rst_tx", 32'(bif.o_tx_data), 32'd0);
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    txn(8'h26, 8'h0F, 8'hFF, 8'hF0);
    txn(8'h27, 8'h0F, 8'hF0, 8'h00);
    txn(8'h02, 8'hF0, 8'h04, 8'h0F);
`ifdef ALU_UART_INTF_TIMEOUT_EN
    send_byte(8'h20);
    repeat (TO) @(posedge clk); #1;
    chk("lit_timeout_err", 32'(bif.o_err), 32'd1);
    send_byte(8'h05);
    chk("lit_after_timeout_err", 32'(bif.o_err), 32'd1);
    txn(8'h20, 8'h01, 8'h01, 8'h02);
`endif
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
